// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction-fetch front end feeding decode through a 2-entry queue
//
// Purpose:
//    Owns the program counter and reads the instruction ROM, which answers
//    combinationally in the same cycle. Each fetched word is captured, tagged
//    with its PC, into a 2-entry queue. The head of the queue goes to decode
//    through a valid/ready handshake. Branch redirects and pipeline flushes
//    empty the queue and restart fetch at the new target. A flush takes
//    priority over a branch.
//
// Ports:
//    clk            in   system clock, rising edge
//    rst            in   asynchronous active-low reset
//    rom_ce         out  ROM chip enable (registered)
//    rom_addr       out  ROM byte address, always equal to the PC
//    rom_inst       in   ROM data, valid in the same cycle as rom_addr
//    id_valid       out  queue head holds an instruction
//    id_ready       in   decode accepts the head this cycle
//    id_pc          out  PC of the head entry (0 when the queue is empty)
//    id_inst        out  instruction of the head entry (0 when the queue is empty)
//    branch_flag    in   redirect request from decode
//    branch_target  in   branch redirect address
//    flush          in   pipeline flush, higher priority than branch_flag
//    new_pc         in   flush redirect address
//    misalign       out  sticky flag: the last redirect target was misaligned
module inst_fetch #(
   parameter int ADDR_W     = 32,
   parameter int INST_W     = 64,
   parameter int RESET_PC   = 0,
   parameter int INST_BYTES = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic              rom_ce,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0] rom_inst,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              flush,
   input  logic [ADDR_W-1:0] new_pc,
   output logic              misalign
);

   // Low address bits that must be zero for an instruction-aligned PC.
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);
   localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INST_BYTES);
   localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] r_pc;
   logic              r_rom_ce;
   logic              r_misalign;

   logic [ADDR_W-1:0] r_q_pc   [2];
   logic [INST_W-1:0] r_q_inst [2];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;

   // ------------------------------------------------------------------
   // Redirect selection and handshake decode
   // ------------------------------------------------------------------
   logic              w_redirect;
   logic [ADDR_W-1:0] w_target;
   logic              w_target_bad;
   logic              w_not_empty;
   logic              w_not_full;
   logic              w_pop;
   logic              w_push;

   assign w_redirect   = flush | branch_flag;
   assign w_target     = flush ? new_pc : branch_target;
   assign w_target_bad = |(w_target & LOW_MASK);

   assign w_not_empty  = (r_count != 2'd0);
   assign w_not_full   = (r_count != 2'd2);

   // A redirect suppresses both sides: whatever sits in the queue or on the
   // ROM bus this cycle belongs to the abandoned path.
   assign w_pop  = w_not_empty & id_ready & ~w_redirect;
   // Popping frees a slot in the same edge, so a full queue still accepts a
   // push when the head is being consumed; this keeps one instruction per cycle.
   assign w_push = r_rom_ce & ~w_redirect & (w_not_full | w_pop);

   // ------------------------------------------------------------------
   // PC, chip enable and misalignment flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc       <= PC_INIT;
         r_rom_ce   <= 1'b0;
         r_misalign <= 1'b0;
      end else if (w_redirect) begin
         // The PC is always kept aligned; a bad target only raises the flag
         // and parks fetch until software redirects again.
         r_pc       <= w_target & ~LOW_MASK;
         r_misalign <= w_target_bad;
         r_rom_ce   <= ~w_target_bad;
      end else begin
         if (w_push) begin
            r_pc <= r_pc + PC_STEP;   // wraps modulo 2^ADDR_W
         end
         r_rom_ce <= ~r_misalign;
      end
   end

   // ------------------------------------------------------------------
   // Two-entry instruction queue
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_q_pc[i]   <= '0;
            r_q_inst[i] <= '0;
         end
      end else if (w_redirect) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_q_pc[r_wr_ptr]   <= r_pc;
            r_q_inst[r_wr_ptr] <= rom_inst;
            r_wr_ptr           <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign rom_ce   = r_rom_ce;
   assign rom_addr = r_pc;
   assign misalign = r_misalign;
   assign id_valid = w_not_empty;
   // Stale entries stay in the array after a pop; mask them so an empty
   // queue always presents zeros to decode.
   assign id_pc    = w_not_empty ? r_q_pc[r_rd_ptr]   : '0;
   assign id_inst  = w_not_empty ? r_q_inst[r_rd_ptr] : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [63:0] rom_inst;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [63:0] id_inst;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        flush;
   logic [31:0] new_pc;
   logic        misalign;

   int n_tests = 0;
   int n_fail  = 0;

   inst_fetch #(
      .ADDR_W(32), .INST_W(64), .RESET_PC(0), .INST_BYTES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
      .branch_flag(branch_flag), .branch_target(branch_target),
      .flush(flush), .new_pc(new_pc), .misalign(misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents: each word encodes its own address so a wrong word is visible.
   function automatic logic [63:0] rom_word(input logic [31:0] a);
      return {a ^ 32'hC0DE_0000, ~a};
   endfunction

   assign rom_inst = rom_word(rom_addr);

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; id_ready = 1'b1; branch_flag = 1'b0; flush = 1'b0;
      branch_target = '0; new_pc = '0;
      tick();
      n_tests++; if (id_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_id_valid got %0b exp 0", id_valid); end
      n_tests++; if (rom_ce !== 1'b0)    begin n_fail++; $display("FAIL reset_rom_ce got %0b exp 0", rom_ce); end
      n_tests++; if (rom_addr !== 32'h0) begin n_fail++; $display("FAIL reset_rom_addr got %h exp 0", rom_addr); end
      n_tests++; if (id_pc !== 32'h0)    begin n_fail++; $display("FAIL reset_id_pc got %h exp 0", id_pc); end
      n_tests++; if (id_inst !== 64'h0)  begin n_fail++; $display("FAIL reset_id_inst got %h exp 0", id_inst); end
      n_tests++; if (misalign !== 1'b0)  begin n_fail++; $display("FAIL reset_misalign got %0b exp 0", misalign); end
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc;
      rst = 1'b1;
      tick();
      n_tests++; if (rom_ce !== 1'b1)   begin n_fail++; $display("FAIL stream_ce_rise got %0b exp 1", rom_ce); end
      n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid_early got %0b exp 0", id_valid); end
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_pc = 32'(i * 8);
         n_tests++; if (id_valid !== 1'b1)          begin n_fail++; $display("FAIL stream_valid[%0d] got %0b exp 1", i, id_valid); end
         n_tests++; if (id_pc !== exp_pc)           begin n_fail++; $display("FAIL stream_pc[%0d] got %h exp %h", i, id_pc, exp_pc); end
         n_tests++; if (id_inst !== rom_word(exp_pc)) begin n_fail++; $display("FAIL stream_inst[%0d] got %h exp %h", i, id_inst, rom_word(exp_pc)); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc;
      id_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      n_tests++; if (rom_addr !== 32'h10) begin n_fail++; $display("FAIL bp_addr_hold got %h exp 10", rom_addr); end
      n_tests++; if (rom_ce !== 1'b1)     begin n_fail++; $display("FAIL bp_ce got %0b exp 1", rom_ce); end
      n_tests++; if (id_pc !== 32'h0)     begin n_fail++; $display("FAIL bp_head got %h exp 0", id_pc); end
      tick();
      n_tests++; if (rom_addr !== 32'h10) begin n_fail++; $display("FAIL bp_addr_hold2 got %h exp 10", rom_addr); end
      id_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         tick();
         exp_pc = 32'(i * 8);
         n_tests++; if (id_pc !== exp_pc)             begin n_fail++; $display("FAIL bp_order_pc[%0d] got %h exp %h", i, id_pc, exp_pc); end
         n_tests++; if (id_inst !== rom_word(exp_pc)) begin n_fail++; $display("FAIL bp_order_inst[%0d] got %h exp %h", i, id_inst, rom_word(exp_pc)); end
      end
   endtask

   task automatic test_branch();
      // Queue was full and draining at full rate, so two entries are held.
      branch_flag = 1'b1; branch_target = 32'h100;
      tick();
      branch_flag = 1'b0;
      n_tests++; if (id_valid !== 1'b0)    begin n_fail++; $display("FAIL br_flush_q got %0b exp 0", id_valid); end
      n_tests++; if (rom_addr !== 32'h100) begin n_fail++; $display("FAIL br_addr got %h exp 100", rom_addr); end
      tick();
      n_tests++; if (id_pc !== 32'h100)    begin n_fail++; $display("FAIL br_id_pc got %h exp 100", id_pc); end
      n_tests++; if (id_inst !== rom_word(32'h100)) begin n_fail++; $display("FAIL br_id_inst got %h exp %h", id_inst, rom_word(32'h100)); end
   endtask

   task automatic test_flush_priority();
      flush = 1'b1; new_pc = 32'h200; branch_flag = 1'b1; branch_target = 32'h100;
      tick();
      flush = 1'b0; branch_flag = 1'b0;
      n_tests++; if (rom_addr !== 32'h200) begin n_fail++; $display("FAIL fl_addr got %h exp 200", rom_addr); end
      n_tests++; if (id_valid !== 1'b0)    begin n_fail++; $display("FAIL fl_empty got %0b exp 0", id_valid); end
      tick();
      n_tests++; if (id_pc !== 32'h200)    begin n_fail++; $display("FAIL fl_id_pc got %h exp 200", id_pc); end
   endtask

   task automatic test_misalign();
      branch_flag = 1'b1; branch_target = 32'h104;
      tick();
      branch_flag = 1'b0;
      n_tests++; if (misalign !== 1'b1)    begin n_fail++; $display("FAIL ma_flag got %0b exp 1", misalign); end
      n_tests++; if (rom_ce !== 1'b0)      begin n_fail++; $display("FAIL ma_ce got %0b exp 0", rom_ce); end
      n_tests++; if (rom_addr !== 32'h100) begin n_fail++; $display("FAIL ma_addr got %h exp 100", rom_addr); end
      tick(); tick();
      n_tests++; if (id_valid !== 1'b0)    begin n_fail++; $display("FAIL ma_valid got %0b exp 0", id_valid); end
      n_tests++; if (rom_ce !== 1'b0)      begin n_fail++; $display("FAIL ma_ce_held got %0b exp 0", rom_ce); end
      n_tests++; if (rom_addr !== 32'h100) begin n_fail++; $display("FAIL ma_addr_held got %h exp 100", rom_addr); end
      flush = 1'b1; new_pc = 32'h40;
      tick();
      flush = 1'b0;
      n_tests++; if (misalign !== 1'b0)    begin n_fail++; $display("FAIL ma_clear got %0b exp 0", misalign); end
      n_tests++; if (rom_ce !== 1'b1)      begin n_fail++; $display("FAIL ma_ce_resume got %0b exp 1", rom_ce); end
      tick();
      n_tests++; if (id_valid !== 1'b1)    begin n_fail++; $display("FAIL ma_valid_resume got %0b exp 1", id_valid); end
      n_tests++; if (id_pc !== 32'h40)     begin n_fail++; $display("FAIL ma_resume_pc got %h exp 40", id_pc); end
   endtask

   task automatic test_async_reset();
      tick();
      #3;
      rst = 1'b0;
      #1;
      n_tests++; if (id_valid !== 1'b0)  begin n_fail++; $display("FAIL ar_valid got %0b exp 0", id_valid); end
      n_tests++; if (rom_ce !== 1'b0)    begin n_fail++; $display("FAIL ar_ce got %0b exp 0", rom_ce); end
      n_tests++; if (rom_addr !== 32'h0) begin n_fail++; $display("FAIL ar_addr got %h exp 0", rom_addr); end
      rst = 1'b1;
      tick();
      n_tests++; if (rom_ce !== 1'b1)    begin n_fail++; $display("FAIL ar_ce_rise got %0b exp 1", rom_ce); end
      tick();
      n_tests++; if (id_valid !== 1'b1)  begin n_fail++; $display("FAIL ar_valid_rise got %0b exp 1", id_valid); end
      n_tests++; if (id_pc !== 32'h0)    begin n_fail++; $display("FAIL ar_restart_pc got %h exp 0", id_pc); end
   endtask

   task automatic test_wrap();
      branch_flag = 1'b1; branch_target = 32'hFFFF_FFF8;
      tick();
      branch_flag = 1'b0;
      n_tests++; if (rom_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wr_addr got %h exp fffffff8", rom_addr); end
      tick();
      n_tests++; if (id_pc !== 32'hFFFF_FFF8)    begin n_fail++; $display("FAIL wr_top_pc got %h exp fffffff8", id_pc); end
      n_tests++; if (rom_addr !== 32'h0)         begin n_fail++; $display("FAIL wr_addr_wrap got %h exp 0", rom_addr); end
      tick();
      n_tests++; if (id_pc !== 32'h0)            begin n_fail++; $display("FAIL wr_wrap_pc got %h exp 0", id_pc); end
      n_tests++; if (id_inst !== rom_word(32'h0)) begin n_fail++; $display("FAIL wr_wrap_inst got %h exp %h", id_inst, rom_word(32'h0)); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_branch();
      test_flush_priority();
      test_misalign();
      test_async_reset();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
